// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//
// Generic in-order pipeline backbone built from per-stage valid / allowin /
// ready_go control. An opaque payload enters at stage 0 (youngest, IF) and
// leaves from stage NSTAGE-1 (oldest, WB). Each stage can stall itself and the
// sink can apply back-pressure. A flush kills every stage younger than a named
// stage.
//
// Handshake: a transfer happens on a rising clk edge when the sender's valid
// and the receiver's allowin/ready are both high in the cycle before that edge.
// The input side uses in_valid/in_allowin and the output side uses
// out_valid/out_ready. Neither side may make valid depend on its own ready.
//
// Ports:
//   clk, resetn           clock and synchronous active-low reset
//   in_valid/in_allowin   new entry offered to stage 0 / stage 0 can take it
//   in_data               payload of the new entry
//   stage_ready_go        bit i: stage i has finished its work this cycle
//   flush, flush_stage    kill stages 0..flush_stage-1 this cycle
//   stage_valid           registered valid of every stage
//   stage_data            registered payload, stage i at [i*DW +: DW]
//   out_valid/out_ready   oldest stage presents an entry / sink accepts it
//   out_data              payload of the oldest stage
//   in_flight             number of valid stages
//   retired_cnt           entries accepted by the sink (wraps)
//   flushed_cnt           valid entries killed by flush (saturates)
// ---------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int NSTAGE = 5,
    parameter int DW     = 64,
    parameter int SW     = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic [DW-1:0]        in_data,
    input  logic [NSTAGE-1:0]    stage_ready_go,
    input  logic                 flush,
    input  logic [SW-1:0]        flush_stage,
    output logic [NSTAGE-1:0]    stage_valid,
    output logic [NSTAGE*DW-1:0] stage_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        in_flight,
    output logic [31:0]          retired_cnt,
    output logic [31:0]          flushed_cnt
);

    logic [NSTAGE-1:0] valid_q;
    logic [DW-1:0]     data_q [NSTAGE];
    logic [NSTAGE-1:0] kill;
    logic [NSTAGE-1:0] go;
    logic [NSTAGE-1:0] allowin;
    logic [SW-1:0]     kill_cnt;
    logic [32:0]       flushed_sum;

    // A stage index below flush_stage is younger than the surviving stage.
    // flush_stage >= NSTAGE therefore kills every stage.
    always_comb begin
        kill = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            kill[i] = flush && (int'(flush_stage) > i);
        end
    end

    // allowin ripples from the sink back to stage 0. A running scalar carries
    // the downstream allowin so the vector never reads itself.
    always_comb begin
        logic nxt;
        nxt     = out_ready;
        allowin = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            allowin[i] = !valid_q[i] || kill[i] || (stage_ready_go[i] && nxt);
            nxt        = allowin[i];
        end
    end

    always_comb begin
        go = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            go[i] = valid_q[i] && stage_ready_go[i] && !kill[i];
        end
    end

    // Stage registers. Stale payload behind valid=0 is left in place.
    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        if (g == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    valid_q[0] <= 1'b0;
                    data_q[0]  <= '0;
                end else if (allowin[0]) begin
                    // The entry offered during a flush is the redirected one
                    // and is accepted.
                    valid_q[0] <= in_valid;
                    if (in_valid) begin
                        data_q[0] <= in_data;
                    end
                end
            end
        end else begin : g_rest
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    valid_q[g] <= 1'b0;
                    data_q[g]  <= '0;
                end else if (allowin[g]) begin
                    valid_q[g] <= go[g-1];
                    if (go[g-1]) begin
                        data_q[g] <= data_q[g-1];
                    end
                end else if (kill[g]) begin
                    valid_q[g] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        in_flight = '0;
        kill_cnt  = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            in_flight = in_flight + SW'(valid_q[i]);
            kill_cnt  = kill_cnt + SW'(valid_q[i] && kill[i]);
        end
    end

    assign flushed_sum = {1'b0, flushed_cnt} + 33'(kill_cnt);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            retired_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            if (out_valid && out_ready) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            flushed_cnt <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
        end
    end

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            stage_data[i*DW +: DW] = data_q[i];
        end
    end

    assign stage_valid = valid_q;
    assign in_allowin  = allowin[0];
    assign out_valid   = valid_q[NSTAGE-1] && stage_ready_go[NSTAGE-1];
    assign out_data    = data_q[NSTAGE-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Directed bench for pipe_stage_chain with NSTAGE=5, DW=32, SW=3. Every
// accepted payload is pushed to exp_q and every payload taken by the sink is
// popped and compared in order. Entries killed by a flush are removed from the
// young end of exp_q by the step that applies the flush.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int NSTAGE = 5;
    localparam int DW     = 32;
    localparam int SW     = 3;

    logic                 clk;
    logic                 resetn;
    logic                 in_valid;
    logic                 in_allowin;
    logic [DW-1:0]        in_data;
    logic [NSTAGE-1:0]    stage_ready_go;
    logic                 flush;
    logic [SW-1:0]        flush_stage;
    logic [NSTAGE-1:0]    stage_valid;
    logic [NSTAGE*DW-1:0] stage_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [SW-1:0]        in_flight;
    logic [31:0]          retired_cnt;
    logic [31:0]          flushed_cnt;

    logic [DW-1:0] exp_q[$];
    int            checks;
    int            failures;
    int            n_kill;
    bit            auto_inc;

    pipe_stage_chain #(.NSTAGE(NSTAGE), .DW(DW), .SW(SW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_allowin     (in_allowin),
        .in_data        (in_data),
        .stage_ready_go (stage_ready_go),
        .flush          (flush),
        .flush_stage    (flush_stage),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .in_flight      (in_flight),
        .retired_cnt    (retired_cnt),
        .flushed_cnt    (flushed_cnt)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] sdata(input int i);
        return stage_data[i*DW +: DW];
    endfunction

    // One clock: apply pending kills to the scoreboard, score the sink
    // transfer, record the accepted input, then advance past the edge.
    task automatic step();
        bit acc;
        bit ret;
        logic [DW-1:0] e;
        #1;
        if (resetn) begin
            repeat (n_kill) begin
                if (exp_q.size() > 0) e = exp_q.pop_back();
            end
        end
        n_kill = 0;
        ret = resetn && out_valid && out_ready;
        if (ret) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(out_data), 64'hDEAD_0000);
            end else begin
                e = exp_q.pop_front();
                chk("out_data_order", 64'(out_data), 64'(e));
            end
        end
        acc = resetn && in_valid && in_allowin;
        if (acc) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
        if (!resetn) exp_q.delete();
        if (acc && auto_inc) in_data = in_data + 1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Fill an empty pipe with five entries starting at base while the sink
    // is held off, leaving every stage valid.
    task automatic fill_full(input logic [DW-1:0] base);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = base;
        auto_inc  = 1'b1;
        steps(5);
        in_valid  = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        n_kill         = 0;
        auto_inc       = 1'b0;
        resetn         = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        stage_ready_go = '1;
        flush          = 1'b0;
        flush_stage    = '0;
        out_ready      = 1'b1;

        @(posedge clk);
        #1;
        steps(2);
        chk("reset_stage_valid", 64'(stage_valid), 64'h0);
        chk("reset_in_flight", 64'(in_flight), 64'h0);
        chk("reset_retired", 64'(retired_cnt), 64'h0);
        chk("reset_flushed", 64'(flushed_cnt), 64'h0);
        chk("reset_stage_data", 64'(stage_data), 64'h0);
        resetn = 1'b1;
        chk("reset_allowin", 64'(in_allowin), 64'h1);
        chk("reset_out_valid", 64'(out_valid), 64'h0);

        // Streaming: 8 entries 0x10..0x17, full throughput.
        in_valid = 1'b1;
        in_data  = 32'h10;
        auto_inc = 1'b1;
        steps(4);
        chk("stream_not_yet_out", 64'(out_valid), 64'h0);
        step();
        chk("stream_first_out_valid", 64'(out_valid), 64'h1);
        chk("stream_first_out_data", 64'(out_data), 64'h10);
        chk("stream_in_flight_full", 64'(in_flight), 64'h5);
        chk("stream_stage0_data", 64'(sdata(0)), 64'h14);
        steps(3);
        in_valid = 1'b0;
        steps(6);
        chk("stream_retired", 64'(retired_cnt), 64'd8);
        chk("stream_drained", 64'(exp_q.size()), 64'h0);
        chk("stream_in_flight_empty", 64'(in_flight), 64'h0);

        // Sink back-pressure on a full pipe.
        fill_full(32'h20);
        steps(3);
        chk("bp_stage_valid", 64'(stage_valid), 64'h1F);
        chk("bp_in_allowin", 64'(in_allowin), 64'h0);
        chk("bp_out_data_frozen", 64'(out_data), 64'h20);
        chk("bp_stage0_frozen", 64'(sdata(0)), 64'h24);
        chk("bp_no_retire", 64'(retired_cnt), 64'd8);
        out_ready = 1'b1;
        steps(6);
        chk("bp_retired", 64'(retired_cnt), 64'd13);
        chk("bp_drained", 64'(exp_q.size()), 64'h0);

        // Mid-pipe stall of stage 2 for two cycles while streaming.
        in_valid = 1'b1;
        in_data  = 32'h30;
        steps(5);
        stage_ready_go[2] = 1'b0;
        step();
        chk("stall_bubble1", 64'(stage_valid), 64'h17);
        chk("stall_stage2_hold", 64'(sdata(2)), 64'h32);
        chk("stall_in_allowin", 64'(in_allowin), 64'h0);
        step();
        chk("stall_bubble2", 64'(stage_valid), 64'h07);
        chk("stall_stage0_hold", 64'(sdata(0)), 64'h34);
        stage_ready_go[2] = 1'b1;
        while (in_data != 32'h3A) step();
        in_valid = 1'b0;
        steps(8);
        chk("stall_retired", 64'(retired_cnt), 64'd23);
        chk("stall_drained", 64'(exp_q.size()), 64'h0);

        // Branch-style flush of stages 0..1 on a full pipe.
        fill_full(32'h40);
        flush       = 1'b1;
        flush_stage = 3'd2;
        in_valid    = 1'b1;
        in_data     = 32'hB0;
        auto_inc    = 1'b0;
        out_ready   = 1'b1;
        n_kill      = 2;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_stage_valid", 64'(stage_valid), 64'h19);
        chk("flush2_stage0_data", 64'(sdata(0)), 64'hB0);
        chk("flush2_stage4_data", 64'(sdata(4)), 64'h41);
        chk("flush2_flushed_cnt", 64'(flushed_cnt), 64'd2);
        steps(6);
        chk("flush2_retired", 64'(retired_cnt), 64'd27);
        chk("flush2_drained", 64'(exp_q.size()), 64'h0);

        // Flush bounds: flush_stage=0 kills nothing, 7 kills everything.
        fill_full(32'h50);
        flush       = 1'b1;
        flush_stage = 3'd0;
        step();
        chk("flush0_stage_valid", 64'(stage_valid), 64'h1F);
        chk("flush0_flushed_cnt", 64'(flushed_cnt), 64'd2);
        flush_stage = 3'd7;
        in_valid    = 1'b1;
        in_data     = 32'hC0;
        auto_inc    = 1'b0;
        n_kill      = 5;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush7_stage_valid", 64'(stage_valid), 64'h01);
        chk("flush7_stage0_data", 64'(sdata(0)), 64'hC0);
        chk("flush7_flushed_cnt", 64'(flushed_cnt), 64'd7);
        chk("flush7_no_retire", 64'(retired_cnt), 64'd27);
        out_ready = 1'b1;
        steps(6);
        chk("flush7_retired", 64'(retired_cnt), 64'd28);
        chk("flush7_drained", 64'(exp_q.size()), 64'h0);

        // Reset in the middle of a full pipe with flush and sink ready.
        fill_full(32'h60);
        resetn      = 1'b0;
        flush       = 1'b1;
        flush_stage = 3'd2;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_data     = 32'hD0;
        auto_inc    = 1'b0;
        step();
        resetn   = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("midrst_stage_valid", 64'(stage_valid), 64'h0);
        chk("midrst_retired", 64'(retired_cnt), 64'h0);
        chk("midrst_flushed", 64'(flushed_cnt), 64'h0);
        chk("midrst_in_flight", 64'(in_flight), 64'h0);
        chk("midrst_stage_data", 64'(stage_data), 64'h0);

        // Random payloads after reset, drained in order.
        in_valid = 1'b1;
        auto_inc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'($urandom_range(32'h0, 32'hFFFF));
            step();
        end
        in_valid = 1'b0;
        steps(6);
        chk("rand_retired", 64'(retired_cnt), 64'd6);
        chk("rand_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
